ahb_apb_periph_bridge: RTL and testbench
========================================

// Module: ahb_apb_periph_bridge
// PURPOSE
//  AHB-Lite slave to APB master bridge; sole upstream feeder of the CLINT APB port and sibling APB peripherals.
//  Converts each AHB transfer into one APB SETUP/ACCESS pair, muxes read data back, adds a PREADY timeout -> HRESP error.
//  Sits between the uncore AHB decoder (which supplies HSEL per peripheral) and the APB peripherals.
// PARAMETERS
//  XLEN     64  data width (32 or 64); PSTRB/HWSTRB width XLEN/8
//  PA_BITS  34  physical address width carried on HADDR/PADDR
//  NSLAVES  2   number of APB peripherals (index 0 = CLINT)
//  TIMEOUT  15  ACCESS cycles without PREADY before error; counter width $clog2(TIMEOUT+1)
// PORTS
//  HCLK       in   1               single clock for AHB and APB sides (PCLK = HCLK)
//  HRESET     in   1               async active-high reset
//  HSEL       in   NSLAVES         one-hot peripheral select from decoder, address phase
//  HADDR      in   PA_BITS         AHB address, address phase
//  HWDATA     in   XLEN            AHB write data, data phase; held by master while HREADYOUT=0
//  HWSTRB     in   XLEN/8          byte strobes, data phase
//  HWRITE     in   1               1 = write, address phase
//  HTRANS     in   2               only bit1 used (NONSEQ/SEQ = valid)
//  HREADY     in   1               global ready; address phase accepted only when 1
//  HRDATA     out  XLEN            read data, valid when HREADYOUT=1 ending a read
//  HREADYOUT  out  1               bridge ready / transfer complete
//  HRESP      out  1               1 = ERROR (two-cycle response)
//  PSEL       out  NSLAVES         one-hot APB select
//  PADDR      out  PA_BITS         registered APB address
//  PWDATA     out  XLEN            = HWDATA (pass-through, stable across SETUP/ACCESS)
//  PSTRB      out  XLEN/8          = HWSTRB for writes, 0 for reads
//  PWRITE     out  1               registered direction
//  PENABLE    out  1               1 in ACCESS only
//  PRDATA     in   NSLAVES*XLEN    flattened read data, slave i at [i*XLEN +: XLEN]
//  PREADY     in   NSLAVES         per-slave ready
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, HREADYOUT=1, HRESP=0, timeout count=0.
//  Accept: start = HREADY & HTRANS[1] & |HSEL; on accept latch HADDR, HWRITE, HSEL -> PADDR/PWRITE/sel_q.
//  FSM IDLE/SETUP/ACCESS/ERR1/ERR2:
//   IDLE:   HREADYOUT=1, PSEL=0; start -> SETUP.
//   SETUP:  PSEL=sel_q, PENABLE=0, HREADYOUT=0 -> ACCESS (always, one cycle).
//   ACCESS: PSEL=sel_q, PENABLE=1; HREADYOUT = PREADY[sel]; count++ each cycle PREADY[sel]=0.
//           PREADY[sel]=1: complete; HRDATA = PRDATA[sel] combinationally; start -> SETUP (back-to-back), else IDLE.
//           count==TIMEOUT with PREADY[sel]=0 -> ERR1 (PSEL/PENABLE drop next cycle).
//   ERR1:   HRESP=1, HREADYOUT=0, PSEL=0 -> ERR2.   ERR2: HRESP=1, HREADYOUT=1; start -> SETUP, else IDLE.
//  Latency: zero-wait slave = 2 cycles after address phase (SETUP, ACCESS); CLINT's registered PRDATA lands in ACCESS.
//  Count clears on entering SETUP; TIMEOUT=0 disables timeout (wait forever).
//  HSEL with >1 bit set: undefined by contract; bridge selects lowest index (priority), no error.
//  HTRANS valid with HSEL=0: ignored (decoder handles unmapped addresses).
//  HRDATA outside a completing read: 0. HRESP=0 outside ERR1/ERR2.
//  PSTRB forced 0 on reads; PWDATA don't-care on reads.
//  Reset asserted mid-ACCESS: PSEL/PENABLE drop immediately; transfer abandoned, no response.
// STRUCTURE
//  State enum apbstatetype {IDLE,SETUP,ACCESS,ERR1,ERR2} goes in the shared cvw package.
//  Sub-module apb_rdata_mux #(XLEN,NSLAVES): one-hot sel -> PRDATA/PREADY select (AND-OR, no priority).
//  FSM, address/select registers and timeout counter in the top module.
// TESTING
//  Write MTIMECMP: HADDR=0x0200_4000, HWDATA=0x1234, HWSTRB=0xFF -> SETUP then ACCESS, PWRITE=1, HREADYOUT=1 two cycles later.
//  Read MTIME at 0x0200_BFF8 after reset -> HRDATA equals CLINT count in ACCESS cycle, HRESP=0.
//  Back-to-back: write 0x0200_0000 MSIP=1 then read same address -> second SETUP immediately after first ACCESS, read returns 1.
//  Slave holds PREADY=0 (TIMEOUT=15) -> 15 ACCESS cycles, then ERR1 (HRESP=1,HREADYOUT=0), ERR2 (HRESP=1,HREADYOUT=1).
//  Slave holds PREADY=0 for 3 cycles -> HREADYOUT=0 for those cycles, completes 4th, no error.
//  Assert HRESET in ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 same cycle; next write proceeds normally.

Source files
------------

// File: rtl/ahb_apb_periph_bridge_pkg.sv
// Shared types for the AHB-Lite to APB peripheral bridge.
// Holds the APB FSM state encoding and a counter-width helper.
package ahb_apb_periph_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR1   = 3'd3,
    ERR2   = 3'd4
  } apbstatetype;

  // A zero timeout still needs a one-bit counter so the declaration stays legal.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    if (timeout > 32'd0) begin
      w = $clog2(timeout + 32'd1);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ahb_apb_periph_bridge_rdata_mux.sv
// One-hot AND-OR select of the addressed APB slave's PRDATA and PREADY.
// No priority: the select vector is expected to be one-hot or zero.
module apb_rdata_mux #(
  parameter int XLEN    = 64,
  parameter int NSLAVES = 2
) (
  input  logic [NSLAVES-1:0]      sel,
  input  logic [NSLAVES*XLEN-1:0] prdata,
  input  logic [NSLAVES-1:0]      pready,
  output logic [XLEN-1:0]         rdata,
  output logic                    ready
);

  // AND-OR reduction across all slaves
  always_comb begin
    rdata = '0;
    ready = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      rdata = rdata | (prdata[i*XLEN +: XLEN] & {XLEN{sel[i]}});
      ready = ready | (pready[i] & sel[i]);
    end
  end

endmodule

// File: rtl/ahb_apb_periph_bridge.sv
// AHB-Lite slave to APB master bridge: one SETUP/ACCESS pair per AHB transfer,
// with a PREADY timeout that turns a stuck slave into a two-cycle HRESP error.
module ahb_apb_periph_bridge
  import ahb_apb_periph_bridge_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 34,
  parameter int NSLAVES = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [NSLAVES-1:0]      HSEL,
  input  logic [PA_BITS-1:0]      HADDR,
  input  logic [XLEN-1:0]         HWDATA,
  input  logic [XLEN/8-1:0]       HWSTRB,
  input  logic                    HWRITE,
  input  logic [1:0]              HTRANS,
  input  logic                    HREADY,
  output logic [XLEN-1:0]         HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [NSLAVES-1:0]      PSEL,
  output logic [PA_BITS-1:0]      PADDR,
  output logic [XLEN-1:0]         PWDATA,
  output logic [XLEN/8-1:0]       PSTRB,
  output logic                    PWRITE,
  output logic                    PENABLE,
  input  logic [NSLAVES*XLEN-1:0] PRDATA,
  input  logic [NSLAVES-1:0]      PREADY
);

  localparam int CW = int'(cnt_width(TIMEOUT));
  localparam logic [NSLAVES-1:0] SEL_ONE = NSLAVES'(1);

  apbstatetype        state_q, state_d;
  logic [PA_BITS-1:0] paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [NSLAVES-1:0] sel_q, sel_d;
  logic [CW-1:0]      count_q, count_d;

  logic               start_s;
  logic               accept_s;
  logic [NSLAVES-1:0] hsel_pri_s;
  logic [XLEN-1:0]    prdata_s;
  logic               pready_s;
  logic               unused_htrans_s;

  assign unused_htrans_s = HTRANS[0];
  assign start_s         = HREADY & HTRANS[1] & (|HSEL);
  // Isolate the lowest set HSEL bit so a malformed multi-hot select stays one-hot.
  assign hsel_pri_s      = HSEL & (~HSEL + SEL_ONE);

  apb_rdata_mux #(.XLEN(XLEN), .NSLAVES(NSLAVES)) u_rdata_mux (
    .sel    (sel_q),
    .prdata (PRDATA),
    .pready (PREADY),
    .rdata  (prdata_s),
    .ready  (pready_s)
  );

  // Next-state, address/select capture and timeout counter
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        accept_s = start_s;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_s) begin
          accept_s = start_s;
          state_d  = IDLE;
        end else begin
          count_d = count_q + CW'(1);
          if ((TIMEOUT != 0) && (count_d == CW'(TIMEOUT))) begin
            state_d = ERR1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ERR1: begin
        state_d = ERR2;
      end
      ERR2: begin
        accept_s = start_s;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept_s) begin
      state_d = SETUP;
      count_d = '0;
    end else begin
      state_d = state_d;
    end
    paddr_d  = accept_s ? HADDR : paddr_q;
    pwrite_d = accept_s ? HWRITE : pwrite_q;
    sel_d    = accept_s ? hsel_pri_s : sel_q;
  end

  // State and transfer registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
    end
  end

  // Bus outputs decoded from the state register so reset clears them at once
  always_comb begin
    PSEL      = '0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state_q)
      IDLE: begin
        HREADYOUT = 1'b1;
      end
      SETUP: begin
        PSEL      = sel_q;
        HREADYOUT = 1'b0;
      end
      ACCESS: begin
        PSEL      = sel_q;
        PENABLE   = 1'b1;
        HREADYOUT = pready_s;
        HRDATA    = (pready_s && !pwrite_q) ? prdata_s : '0;
      end
      ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
      end
      ERR2: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = HWDATA;
  assign PSTRB  = pwrite_q ? HWSTRB : '0;

endmodule

// File: tb/tb_ahb_apb_periph_bridge.sv
// Directed bench for ahb_apb_periph_bridge: a per-cycle vector table plus
// hand-written timeout, slow-slave and reset-in-ACCESS sequences.
module tb_ahb_apb_periph_bridge;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [1:0]   HSEL;
  logic [33:0]  HADDR;
  logic [63:0]  HWDATA;
  logic [7:0]   HWSTRB;
  logic         HWRITE;
  logic [1:0]   HTRANS;
  logic         HREADY;
  logic [63:0]  HRDATA;
  logic         HREADYOUT;
  logic         HRESP;
  logic [1:0]   PSEL;
  logic [33:0]  PADDR;
  logic [63:0]  PWDATA;
  logic [7:0]   PSTRB;
  logic         PWRITE;
  logic         PENABLE;
  logic [63:0]  prd0, prd1;
  logic [127:0] PRDATA;
  logic [1:0]   PREADY;

  assign PRDATA = {prd1, prd0};

  ahb_apb_periph_bridge #(.XLEN(64), .PA_BITS(34), .NSLAVES(2), .TIMEOUT(15)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWSTRB(HWSTRB), .HWRITE(HWRITE), .HTRANS(HTRANS), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PSEL(PSEL),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  hsel;
    logic [33:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic        hready;
    logic [63:0] hwdata;
    logic [7:0]  hwstrb;
    logic [1:0]  pready;
    logic [63:0] prd0;
    logic [63:0] prd1;
    logic [1:0]  e_psel;
    logic        e_pen;
    logic        e_hro;
    logic        e_hresp;
    logic [63:0] e_hrdata;
    logic [33:0] e_paddr;
    logic        e_pwrite;
    logic [7:0]  e_pstrb;
  } vec_t;

  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in();
    HSEL = 2'b00; HADDR = 34'h0; HWRITE = 1'b0; HTRANS = 2'b00; HREADY = 1'b0;
    HWDATA = 64'h0; HWSTRB = 8'h00; PREADY = 2'b00; prd0 = 64'h0; prd1 = 64'h0;
  endtask

  task automatic addr_phase(input logic [1:0] sel, input logic [33:0] addr, input logic wr);
    HSEL = sel; HADDR = addr; HWRITE = wr; HTRANS = 2'b10; HREADY = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 34'h0_0200_4000, 1'b1, 2'b10, 1'b1, 64'h0,    8'h00, 2'b00, 64'h0,    64'h0,    2'b00, 1'b0, 1'b1, 1'b0, 64'h0,    34'h0,           1'b0, 8'h00};
    vecs[1]  = '{2'b00, 34'h0,           1'b0, 2'b00, 1'b0, 64'h1234, 8'hFF, 2'b00, 64'h0,    64'h0,    2'b01, 1'b0, 1'b0, 1'b0, 64'h0,    34'h0_0200_4000, 1'b1, 8'hFF};
    vecs[2]  = '{2'b01, 34'h0_0200_BFF8, 1'b0, 2'b10, 1'b1, 64'h1234, 8'hFF, 2'b01, 64'h55,   64'h0,    2'b01, 1'b1, 1'b1, 1'b0, 64'h0,    34'h0_0200_4000, 1'b1, 8'hFF};
    vecs[3]  = '{2'b00, 34'h0,           1'b0, 2'b00, 1'b0, 64'h0,    8'hFF, 2'b01, 64'h0,    64'h0,    2'b01, 1'b0, 1'b0, 1'b0, 64'h0,    34'h0_0200_BFF8, 1'b0, 8'h00};
    vecs[4]  = '{2'b10, 34'h0_1000_0010, 1'b0, 2'b10, 1'b1, 64'h0,    8'h00, 2'b01, 64'hABCD, 64'h1111, 2'b01, 1'b1, 1'b1, 1'b0, 64'hABCD, 34'h0_0200_BFF8, 1'b0, 8'h00};
    vecs[5]  = '{2'b00, 34'h0,           1'b0, 2'b00, 1'b0, 64'h0,    8'h00, 2'b00, 64'h0,    64'h0,    2'b10, 1'b0, 1'b0, 1'b0, 64'h0,    34'h0_1000_0010, 1'b0, 8'h00};
    vecs[6]  = '{2'b00, 34'h0,           1'b0, 2'b00, 1'b0, 64'h0,    8'h00, 2'b01, 64'h77,   64'hDEAD, 2'b10, 1'b1, 1'b0, 1'b0, 64'h0,    34'h0_1000_0010, 1'b0, 8'h00};
    vecs[7]  = '{2'b11, 34'h20,          1'b1, 2'b11, 1'b1, 64'h0,    8'h00, 2'b10, 64'h77,   64'hDEAD, 2'b10, 1'b1, 1'b1, 1'b0, 64'hDEAD, 34'h0_1000_0010, 1'b0, 8'h00};
    vecs[8]  = '{2'b00, 34'h0,           1'b0, 2'b00, 1'b0, 64'hAA,   8'h0F, 2'b00, 64'h0,    64'h0,    2'b01, 1'b0, 1'b0, 1'b0, 64'h0,    34'h20,          1'b1, 8'h0F};
    vecs[9]  = '{2'b00, 34'h30,          1'b0, 2'b10, 1'b1, 64'hAA,   8'h0F, 2'b11, 64'h99,   64'h0,    2'b01, 1'b1, 1'b1, 1'b0, 64'h0,    34'h20,          1'b1, 8'h0F};
    vecs[10] = '{2'b01, 34'h40,          1'b0, 2'b10, 1'b0, 64'h0,    8'h00, 2'b00, 64'h0,    64'h0,    2'b00, 1'b0, 1'b1, 1'b0, 64'h0,    34'h20,          1'b1, 8'h00};
    vecs[11] = '{2'b00, 34'h0,           1'b0, 2'b00, 1'b1, 64'h0,    8'h00, 2'b00, 64'h0,    64'h0,    2'b00, 1'b0, 1'b1, 1'b0, 64'h0,    34'h20,          1'b1, 8'h00};

    idle_in();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #3;
    chk("reset psel", 64'(PSEL), 64'h0);
    chk("reset penable", 64'(PENABLE), 64'h0);
    chk("reset hreadyout", 64'(HREADYOUT), 64'h1);
    chk("reset hresp", 64'(HRESP), 64'h0);
    chk("reset paddr", 64'(PADDR), 64'h0);
    chk("reset pwrite", 64'(PWRITE), 64'h0);
    tick();
    HRESET = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      HSEL = vecs[i].hsel; HADDR = vecs[i].haddr; HWRITE = vecs[i].hwrite;
      HTRANS = vecs[i].htrans; HREADY = vecs[i].hready; HWDATA = vecs[i].hwdata;
      HWSTRB = vecs[i].hwstrb; PREADY = vecs[i].pready; prd0 = vecs[i].prd0; prd1 = vecs[i].prd1;
      #4;
      chk($sformatf("r%0d psel", i), 64'(PSEL), 64'(vecs[i].e_psel));
      chk($sformatf("r%0d penable", i), 64'(PENABLE), 64'(vecs[i].e_pen));
      chk($sformatf("r%0d hreadyout", i), 64'(HREADYOUT), 64'(vecs[i].e_hro));
      chk($sformatf("r%0d hresp", i), 64'(HRESP), 64'(vecs[i].e_hresp));
      chk($sformatf("r%0d hrdata", i), HRDATA, vecs[i].e_hrdata);
      chk($sformatf("r%0d paddr", i), 64'(PADDR), 64'(vecs[i].e_paddr));
      chk($sformatf("r%0d pwrite", i), 64'(PWRITE), 64'(vecs[i].e_pwrite));
      chk($sformatf("r%0d pstrb", i), 64'(PSTRB), 64'(vecs[i].e_pstrb));
      chk($sformatf("r%0d pwdata", i), PWDATA, vecs[i].hwdata);
      tick();
    end

    // Stuck slave: 15 ACCESS cycles then ERR1/ERR2, new read launched from ERR2
    idle_in();
    addr_phase(2'b01, 34'h100, 1'b1);
    #4; tick();
    idle_in(); HWDATA = 64'h5; HWSTRB = 8'hFF;
    #4; chk("to setup psel", 64'(PSEL), 64'h1);
    tick();
    for (int k = 0; k < 15; k++) begin
      PREADY = 2'b00;
      #4;
      chk($sformatf("to access%0d penable", k), 64'(PENABLE), 64'h1);
      chk($sformatf("to access%0d hreadyout", k), 64'(HREADYOUT), 64'h0);
      chk($sformatf("to access%0d hresp", k), 64'(HRESP), 64'h0);
      tick();
    end
    #4;
    chk("err1 hresp", 64'(HRESP), 64'h1);
    chk("err1 hreadyout", 64'(HREADYOUT), 64'h0);
    chk("err1 psel", 64'(PSEL), 64'h0);
    chk("err1 penable", 64'(PENABLE), 64'h0);
    tick();
    addr_phase(2'b01, 34'h200, 1'b0);
    #4;
    chk("err2 hresp", 64'(HRESP), 64'h1);
    chk("err2 hreadyout", 64'(HREADYOUT), 64'h1);
    chk("err2 psel", 64'(PSEL), 64'h0);
    tick();

    // Slow slave: three wait cycles then completion, no error
    idle_in();
    #4;
    chk("slow setup psel", 64'(PSEL), 64'h1);
    chk("slow setup hresp", 64'(HRESP), 64'h0);
    chk("slow setup paddr", 64'(PADDR), 64'h200);
    tick();
    for (int k = 0; k < 3; k++) begin
      PREADY = 2'b00; prd0 = 64'hBEEF;
      #4;
      chk($sformatf("slow wait%0d hreadyout", k), 64'(HREADYOUT), 64'h0);
      chk($sformatf("slow wait%0d hrdata", k), HRDATA, 64'h0);
      chk($sformatf("slow wait%0d penable", k), 64'(PENABLE), 64'h1);
      tick();
    end
    PREADY = 2'b01; prd0 = 64'hBEEF;
    #4;
    chk("slow done hreadyout", 64'(HREADYOUT), 64'h1);
    chk("slow done hrdata", HRDATA, 64'hBEEF);
    chk("slow done hresp", 64'(HRESP), 64'h0);
    tick();
    idle_in();
    #4;
    chk("slow idle hresp", 64'(HRESP), 64'h0);
    chk("slow idle psel", 64'(PSEL), 64'h0);
    chk("slow idle hreadyout", 64'(HREADYOUT), 64'h1);
    tick();

    // Reset asserted while in ACCESS, then a clean MSIP write
    addr_phase(2'b01, 34'h300, 1'b1);
    #4; tick();
    idle_in(); HWDATA = 64'h9;
    #4; tick();
    PREADY = 2'b00;
    #1;
    chk("pre-reset penable", 64'(PENABLE), 64'h1);
    #1 HRESET = 1'b1;
    #1;
    chk("mid reset psel", 64'(PSEL), 64'h0);
    chk("mid reset penable", 64'(PENABLE), 64'h0);
    chk("mid reset hreadyout", 64'(HREADYOUT), 64'h1);
    chk("mid reset paddr", 64'(PADDR), 64'h0);
    #1 HRESET = 1'b0;
    tick();
    addr_phase(2'b01, 34'h0_0200_0000, 1'b1);
    #4;
    chk("post reset idle hreadyout", 64'(HREADYOUT), 64'h1);
    tick();
    idle_in(); HWDATA = 64'h1; HWSTRB = 8'hFF;
    #4;
    chk("post reset setup psel", 64'(PSEL), 64'h1);
    chk("post reset setup paddr", 64'(PADDR), 64'h0_0200_0000);
    chk("post reset setup pwrite", 64'(PWRITE), 64'h1);
    chk("post reset setup pstrb", 64'(PSTRB), 64'hFF);
    chk("post reset setup pwdata", PWDATA, 64'h1);
    tick();
    PREADY = 2'b01;
    #4;
    chk("post reset access penable", 64'(PENABLE), 64'h1);
    chk("post reset access hreadyout", 64'(HREADYOUT), 64'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
